// File: rtl/gp_pkg.sv
// Shared definitions for the multi-port GP register file: write-mode encodings and default sizes.
package gp_pkg;

    typedef enum logic [1:0] {
        WM_IDLE   = 2'b00,
        WM_ALU    = 2'b01,
        WM_LOAD   = 2'b10,
        WM_DIRECT = 2'b11
    } wr_mode_e;

    localparam int GP_DATA_W   = 32;
    localparam int GP_ADDR_W   = 3;
    localparam int GP_MAX_PEND = 4;

endpackage : gp_pkg

// File: rtl/gp_scoreboard.sv
// Load scoreboard: busy bits, outstanding-load count, issue/return legality and the error pulse.
module gp_scoreboard
    import gp_pkg::*;
#(
    parameter int ADDR_W   = GP_ADDR_W,
    parameter int MAX_PEND = GP_MAX_PEND,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] sel_x,
    input  logic [ADDR_W-1:0] sel_y,
    input  logic [ADDR_W-1:0] sel_z,
    input  logic [1:0]        wr_mode,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_tag,
    output logic              a_busy,
    output logic              b_busy,
    output logic              wr_ready,
    output logic              commit_en,
    output logic              commit_ld,
    output logic [ADDR_W-1:0] commit_idx,
    output logic [ADDR_W:0]   pend_cnt,
    output logic              err
);

    localparam int              DEPTH      = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] MAX_PEND_C = (ADDR_W + 1)'(MAX_PEND);
    localparam logic [ADDR_W:0] ONE_C      = (ADDR_W + 1)'(1);

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [ADDR_W:0]  pend_q, pend_d;
    logic             err_q, err_d;
    wr_mode_e         mode_s;
    logic             zero_z_s, ld_hit_s, issue_s, wr_commit_s, wr_ready_s;

    // Request legality, commit selection and scoreboard next state
    always_comb begin
        mode_s      = wr_mode_e'(wr_mode);
        zero_z_s    = ZERO_REG && (sel_z == '0);
        ld_hit_s    = ld_valid && busy_q[ld_tag];
        wr_ready_s  = !ld_valid &&
                      ((mode_s != WM_LOAD) || ((pend_q < MAX_PEND_C) && !busy_q[sel_z]));
        issue_s     = 1'b0;
        wr_commit_s = 1'b0;
        err_d       = ld_valid && !busy_q[ld_tag];
        if (wr_ready_s) begin
            case (mode_s)
                WM_ALU, WM_DIRECT: begin
                    wr_commit_s = !zero_z_s && !busy_q[sel_z];
                    err_d       = !zero_z_s && busy_q[sel_z];
                end
                WM_LOAD: begin
                    issue_s = !zero_z_s;
                    err_d   = zero_z_s;
                end
                default: begin
                    issue_s     = 1'b0;
                    wr_commit_s = 1'b0;
                end
            endcase
        end else begin
            issue_s     = 1'b0;
            wr_commit_s = 1'b0;
        end

        busy_d = busy_q;
        if (ld_hit_s) begin
            busy_d[ld_tag] = 1'b0;
        end else if (issue_s) begin
            busy_d[sel_z] = 1'b1;
        end else begin
            busy_d = busy_q;
        end

        case ({issue_s, ld_hit_s})
            2'b10:   pend_d = pend_q + ONE_C;
            2'b01:   pend_d = pend_q - ONE_C;
            default: pend_d = pend_q;
        endcase
    end

    // Scoreboard state and registered error pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    assign a_busy     = busy_q[sel_x];
    assign b_busy     = busy_q[sel_y];
    assign wr_ready   = wr_ready_s;
    assign commit_en  = ld_hit_s || wr_commit_s;
    assign commit_ld  = ld_hit_s;
    assign commit_idx = ld_hit_s ? ld_tag : sel_z;
    assign pend_cnt   = pend_q;
    assign err        = err_q;

endmodule : gp_scoreboard

// File: rtl/gp_regfile_mp.sv
// Multi-port GP register file: two combinational read ports with optional bypass, one shared
// write port arbitrated between load returns and ALU/direct writes.
module gp_regfile_mp
    import gp_pkg::*;
#(
    parameter int DATA_W   = GP_DATA_W,
    parameter int ADDR_W   = GP_ADDR_W,
    parameter int MAX_PEND = GP_MAX_PEND,
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] sel_x,
    input  logic [ADDR_W-1:0] sel_y,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic              a_busy,
    output logic              b_busy,
    input  logic [ADDR_W-1:0] sel_z,
    input  logic [1:0]        wr_mode,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] mem_data,
    output logic              wr_ready,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_tag,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic [ADDR_W:0]   pend_cnt,
    output logic              err
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic              commit_en_s, commit_ld_s;
    logic [ADDR_W-1:0] commit_idx_s;
    logic [DATA_W-1:0] commit_data_s, a_s, b_s;

    gp_scoreboard #(
        .ADDR_W   (ADDR_W),
        .MAX_PEND (MAX_PEND),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .sel_x      (sel_x),
        .sel_y      (sel_y),
        .sel_z      (sel_z),
        .wr_mode    (wr_mode),
        .ld_valid   (ld_valid),
        .ld_tag     (ld_tag),
        .a_busy     (a_busy),
        .b_busy     (b_busy),
        .wr_ready   (wr_ready),
        .commit_en  (commit_en_s),
        .commit_ld  (commit_ld_s),
        .commit_idx (commit_idx_s),
        .pend_cnt   (pend_cnt),
        .err        (err)
    );

    // Write-port data source and register array next state
    always_comb begin
        if (commit_ld_s) begin
            commit_data_s = ld_data;
        end else if (wr_mode == WM_ALU) begin
            commit_data_s = wr_data;
        end else begin
            commit_data_s = mem_data;
        end
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = (commit_en_s && (commit_idx_s == ADDR_W'(i))) ? commit_data_s : regs_q[i];
        end
    end

    // Read muxes: hard zero first, then same-cycle bypass of the committing write
    always_comb begin
        if (ZERO_REG && (sel_x == '0)) begin
            a_s = '0;
        end else if (BYPASS && commit_en_s && (commit_idx_s == sel_x)) begin
            a_s = commit_data_s;
        end else begin
            a_s = regs_q[sel_x];
        end
        if (ZERO_REG && (sel_y == '0)) begin
            b_s = '0;
        end else if (BYPASS && commit_en_s && (commit_idx_s == sel_y)) begin
            b_s = commit_data_s;
        end else begin
            b_s = regs_q[sel_y];
        end
    end

    // Register array storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign a        = a_s;
    assign b        = b_s;
    assign ld_ready = 1'b1;

endmodule : gp_regfile_mp

// File: tb/tb_gp_regfile_mp.sv
// Directed scoreboard bench for gp_regfile_mp: a default instance (bypass on) and a
// bypass-off, hard-zero instance share the same stimulus.
module tb_gp_regfile_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  sel_x = 3'd0, sel_y = 3'd0, sel_z = 3'd0, ld_tag = 3'd0;
    logic [1:0]  wr_mode = 2'b00;
    logic [31:0] wr_data = 32'd0, mem_data = 32'd0, ld_data = 32'd0;
    logic        ld_valid = 1'b0;

    logic [31:0] a, b, a_nb, b_nb;
    logic        a_busy, b_busy, wr_ready, ld_ready, err;
    logic        a_busy_nb, b_busy_nb, wr_ready_nb, ld_ready_nb, err_nb;
    logic [3:0]  pend_cnt, pend_cnt_nb;

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    gp_regfile_mp dut (
        .clk(clk), .rst(rst), .sel_x(sel_x), .sel_y(sel_y), .a(a), .b(b),
        .a_busy(a_busy), .b_busy(b_busy), .sel_z(sel_z), .wr_mode(wr_mode),
        .wr_data(wr_data), .mem_data(mem_data), .wr_ready(wr_ready),
        .ld_valid(ld_valid), .ld_tag(ld_tag), .ld_data(ld_data),
        .ld_ready(ld_ready), .pend_cnt(pend_cnt), .err(err)
    );

    gp_regfile_mp #(.ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .sel_x(sel_x), .sel_y(sel_y), .a(a_nb), .b(b_nb),
        .a_busy(a_busy_nb), .b_busy(b_busy_nb), .sel_z(sel_z), .wr_mode(wr_mode),
        .wr_data(wr_data), .mem_data(mem_data), .wr_ready(wr_ready_nb),
        .ld_valid(ld_valid), .ld_tag(ld_tag), .ld_data(ld_data),
        .ld_ready(ld_ready_nb), .pend_cnt(pend_cnt_nb), .err(err_nb)
    );

    task automatic push(input string t, input logic [63:0] e);
        q.push_back('{t, e});
    endtask

    task automatic chk(input logic [63:0] obs);
        exp_t e;
        n_chk++;
        if (q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_underflow: observed %0h with no expected entry", obs);
        end else begin
            e = q.pop_front();
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] v;

        // Reset state
        #3;
        push("rst_pend", 64'd0);     chk(64'(pend_cnt));
        push("rst_err", 64'd0);      chk(64'(err));
        push("rst_a", 64'd0);        chk(64'(a));
        push("rst_wr_ready", 64'd1); chk(64'(wr_ready));
        push("rst_ld_ready", 64'd1); chk(64'(ld_ready));
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Direct writes to every register, read back on both ports
        for (int c = 0; c < 8; c++) begin
            v        = 32'(55 * c + 1);
            wr_mode  = 2'b11;
            sel_z    = 3'(c);
            mem_data = v;
            #1;
            push("wr_ready_direct", 64'd1); chk(64'(wr_ready));
            step();
            wr_mode = 2'b00;
            sel_x   = 3'(c);
            sel_y   = 3'(c);
            #1;
            push($sformatf("a_r%0d", c), 64'(v)); chk(64'(a));
            push($sformatf("b_r%0d", c), 64'(v)); chk(64'(b));
            push("err_direct", 64'd0);            chk(64'(err));
            push($sformatf("nb_a_r%0d", c), (c == 0) ? 64'd0 : 64'(v)); chk(64'(a_nb));
        end

        // Issue loads to r1..r4, then a fifth issue blocked by the count
        for (int i = 1; i <= 4; i++) begin
            wr_mode = 2'b10;
            sel_z   = 3'(i);
            #1;
            push("wr_ready_issue", 64'd1); chk(64'(wr_ready));
            step();
            push($sformatf("pend_after_issue%0d", i), 64'(i)); chk(64'(pend_cnt));
        end
        sel_z = 3'd5;
        #1;
        push("wr_ready_full", 64'd0); chk(64'(wr_ready));
        step();
        push("pend_full", 64'd4); chk(64'(pend_cnt));
        wr_mode = 2'b00;
        sel_x   = 3'd3;
        sel_y   = 3'd5;
        #1;
        push("a_busy_r3", 64'd1);   chk(64'(a_busy));
        push("b_busy_r5", 64'd0);   chk(64'(b_busy));
        push("err_full", 64'd0);    chk(64'(err));

        // Load return wins the write port over a same-cycle ALU write
        ld_valid = 1'b1;
        ld_tag   = 3'd2;
        ld_data  = 32'hDEADBEEF;
        wr_mode  = 2'b01;
        sel_z    = 3'd6;
        wr_data  = 32'hCAFE0006;
        sel_x    = 3'd2;
        sel_y    = 3'd6;
        #1;
        push("wr_ready_during_ld", 64'd0);     chk(64'(wr_ready));
        push("a_bypass_ld", 64'hDEADBEEF);     chk(64'(a));
        step();
        ld_valid = 1'b0;
        #1;
        push("pend_after_ret", 64'd3);         chk(64'(pend_cnt));
        push("err_after_ret", 64'd0);          chk(64'(err));
        push("r2_loaded", 64'hDEADBEEF);       chk(64'(a));
        push("busy_r2_clear", 64'd0);          chk(64'(a_busy));
        push("r6_held", 64'd331);              chk(64'(b_nb));
        push("wr_ready_retry", 64'd1);         chk(64'(wr_ready));
        step();
        wr_mode = 2'b00;
        #1;
        push("r6_written", 64'hCAFE0006);      chk(64'(b));

        // Same-cycle bypass versus no bypass
        wr_mode = 2'b01;
        sel_z   = 3'd5;
        sel_x   = 3'd5;
        wr_data = 32'h00001234;
        #1;
        push("bypass_a", 64'h1234);            chk(64'(a));
        push("nobypass_a_old", 64'd276);       chk(64'(a_nb));
        step();
        wr_mode = 2'b00;
        #1;
        push("nobypass_a_new", 64'h1234);      chk(64'(a_nb));

        // WAW against an outstanding load
        wr_mode = 2'b01;
        sel_z   = 3'd3;
        wr_data = 32'h00000BAD;
        step();
        wr_mode = 2'b00;
        sel_x   = 3'd3;
        #1;
        push("err_waw", 64'd1);                chk(64'(err));
        push("r3_unchanged", 64'd166);         chk(64'(a));
        step();
        push("err_waw_pulse_end", 64'd0);      chk(64'(err));

        // Return for a non-busy register
        ld_valid = 1'b1;
        ld_tag   = 3'd7;
        ld_data  = 32'h00000777;
        step();
        ld_valid = 1'b0;
        sel_x    = 3'd7;
        #1;
        push("err_stray_ret", 64'd1);          chk(64'(err));
        push("r7_unchanged", 64'd386);         chk(64'(a));
        push("pend_stray_ret", 64'd3);         chk(64'(pend_cnt));
        step();
        push("err_stray_end", 64'd0);          chk(64'(err));

        // Asynchronous reset mid-cycle with three loads pending
        sel_x = 3'd7;
        sel_y = 3'd1;
        #2 rst = 1'b0;
        #1;
        push("rst_mid_pend", 64'd0);           chk(64'(pend_cnt));
        push("rst_mid_a", 64'd0);              chk(64'(a));
        push("rst_mid_busy", 64'd0);           chk(64'(b_busy));
        step();
        rst      = 1'b1;
        ld_valid = 1'b1;
        ld_tag   = 3'd1;
        ld_data  = 32'h11111111;
        step();
        ld_valid = 1'b0;
        #1;
        push("err_pre_reset_ret", 64'd1);      chk(64'(err));
        push("r1_not_written", 64'd0);         chk(64'(b));
        push("pend_post_reset", 64'd0);        chk(64'(pend_cnt));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_gp_regfile_mp
